// File: rtl/multicycle_ctlpath_pkg.sv
// ============================================================================
//  Module      : multicycle_ctlpath_pkg
//  Description : Shared constants for the multicycle RV32I control path:
//                opcodes, FSM state type, ALU function codes and the
//                encodings of the datapath mux selects.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctlpath_pkg;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Operation class handed to the ALU function decoder
    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'd0,
        ALU_OP_OP     = 2'd1,
        ALU_OP_OPIMM  = 2'd2,
        ALU_OP_BRANCH = 2'd3
    } alu_op_t;

    // ALU function codes
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    // Register writeback source
    localparam logic [2:0] WB_ALUOUT = 3'd0;
    localparam logic [2:0] WB_MDR    = 3'd1;
    localparam logic [2:0] WB_IMM    = 3'd2;
    localparam logic [2:0] WB_PC     = 3'd3;

    // ALU operand selects
    localparam logic [1:0] OPA_RS1    = 2'd0;
    localparam logic [1:0] OPA_PC_OLD = 2'd1;
    localparam logic [1:0] OPA_PC     = 2'd2;
    localparam logic [1:0] OPB_RS2    = 2'd0;
    localparam logic [1:0] OPB_IMM    = 2'd1;
    localparam logic [1:0] OPB_FOUR   = 2'd2;

    // Next-PC source
    localparam logic [1:0] NPC_ALU    = 2'd0;
    localparam logic [1:0] NPC_ALUOUT = 2'd1;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctlpath_alu_control.sv
// ============================================================================
//  Module      : alu_control
//  Description : Maps operation class, funct3 and funct7 to the ALU function
//                code. Branches map to the compare that feeds the zero flag.
//                M-extension codes are always decoded; legality is decided by
//                the instantiating control path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
    import multicycle_ctlpath_pkg::*;
(
    input  alu_op_t    alu_op_type_i,
    input  logic [2:0] inst_funct3_i,
    input  logic [6:0] inst_funct7_i,
    output logic [4:0] alu_function_o
);

    // Combinational function decode
    always_comb begin
        alu_function_o = ALU_ADD;
        case (alu_op_type_i)
            ALU_OP_BRANCH: begin
                // BEQ/BNE compare by subtraction, signed/unsigned order by SLT(U)
                case (inst_funct3_i[2:1])
                    2'b10:   alu_function_o = ALU_SLT;
                    2'b11:   alu_function_o = ALU_SLTU;
                    default: alu_function_o = ALU_SUB;
                endcase
            end
            ALU_OP_OP, ALU_OP_OPIMM: begin
                if (alu_op_type_i == ALU_OP_OP && inst_funct7_i == FUNCT7_MULDIV) begin
                    case (inst_funct3_i)
                        3'b000:  alu_function_o = ALU_MUL;
                        3'b001:  alu_function_o = ALU_MULH;
                        3'b010:  alu_function_o = ALU_MULHSU;
                        3'b011:  alu_function_o = ALU_MULHU;
                        3'b100:  alu_function_o = ALU_DIV;
                        3'b101:  alu_function_o = ALU_DIVU;
                        3'b110:  alu_function_o = ALU_REM;
                        default: alu_function_o = ALU_REMU;
                    endcase
                end else begin
                    case (inst_funct3_i)
                        // SUB only exists in register form; ADDI's funct7 bits are immediate
                        3'b000:  alu_function_o = (alu_op_type_i == ALU_OP_OP && inst_funct7_i[5])
                                                  ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_function_o = ALU_SLL;
                        3'b010:  alu_function_o = ALU_SLT;
                        3'b011:  alu_function_o = ALU_SLTU;
                        3'b100:  alu_function_o = ALU_XOR;
                        3'b101:  alu_function_o = inst_funct7_i[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_function_o = ALU_OR;
                        default: alu_function_o = ALU_AND;
                    endcase
                end
            end
            default: alu_function_o = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctlpath.sv
// ============================================================================
//  Module      : multicycle_ctlpath
//  Description : Control path of the multicycle RV32I core. Sequences each
//                instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a
//                shared, ready-handshaked memory port, with a bounded wait
//                timeout into a sticky FAULT state and a retired counter.
//                Optional feature macro: RVSIMPLE_MULDIV_EN (M-extension wait
//                on muldiv_done in EXECUTE).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctlpath
    import multicycle_ctlpath_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           inst_opcode,
    input  logic [2:0]           inst_funct3,
    input  logic [6:0]           inst_funct7,
    input  logic                 alu_result_equal_zero,
    input  logic                 mem_ready,
`ifdef RVSIMPLE_MULDIV_EN
    input  logic                 muldiv_done,
`endif
    output logic [4:0]           alu_function,
    output logic                 pc_write_enable,
    output logic                 pc_old_write_enable,
    output logic                 inst_write_enable,
    output logic                 data_write_enable,
    output logic                 regfile_write_enable,
    output logic                 mem_addr_select,
    output logic                 mem_read_enable,
    output logic                 mem_write_enable,
    output logic [1:0]           alu_operand_a_select,
    output logic [1:0]           alu_operand_b_select,
    output logic [2:0]           reg_writeback_select,
    output logic [1:0]           next_pc_select,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 fault_q, fault_d;

    logic                 w_is_load, w_is_store, w_is_lui, w_is_muldiv, w_illegal;
    logic                 w_taken, w_timeout;
    logic [WAIT_W-1:0]    w_wait_inc;
    alu_op_t              w_alu_op;
    logic [4:0]           w_alu_fn;

    assign w_is_load   = (inst_opcode == OPC_LOAD);
    assign w_is_store  = (inst_opcode == OPC_STORE);
    assign w_is_lui    = (inst_opcode == OPC_LUI);
    assign w_is_muldiv = (inst_opcode == OPC_OP) && (inst_funct7 == FUNCT7_MULDIV);
    assign w_wait_inc  = wait_q + WAIT_W'(1);
    // The cycle whose wait would bring the count to the limit is the last one allowed
    assign w_timeout   = (w_wait_inc == WAIT_LIMIT);

    // Legal opcode check; M-extension encodings are illegal unless the feature is built in
    always_comb begin
        case (inst_opcode)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: w_illegal = 1'b0;
            default:                                 w_illegal = 1'b1;
        endcase
`ifndef RVSIMPLE_MULDIV_EN
        if (w_is_muldiv) begin
            w_illegal = 1'b1;
        end
`endif
    end

    // Branch decision from funct3 and the ALU zero flag (SUB for EQ/NE, SLT(U) for order)
    always_comb begin
        case (inst_funct3)
            3'b000:  w_taken =  alu_result_equal_zero;
            3'b001:  w_taken = !alu_result_equal_zero;
            3'b100:  w_taken = !alu_result_equal_zero;
            3'b101:  w_taken =  alu_result_equal_zero;
            3'b110:  w_taken = !alu_result_equal_zero;
            3'b111:  w_taken =  alu_result_equal_zero;
            default: w_taken = 1'b0;
        endcase
    end

    // Next state, wait counter, retirement counter and sticky fault
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready)      state_d = ST_DECODE;
                else if (w_timeout) state_d = ST_FAULT;
                else                wait_d  = w_wait_inc;
            end
            ST_DECODE:  state_d = w_illegal ? ST_FAULT : ST_EXECUTE;
            ST_EXECUTE: begin
                case (inst_opcode)
                    OPC_LOAD, OPC_STORE:            state_d = ST_MEM;
                    OPC_BRANCH, OPC_JAL, OPC_JALR:  state_d = ST_FETCH;
                    default: begin
                        state_d = ST_WRITEBACK;
`ifdef RVSIMPLE_MULDIV_EN
                        // Multiply/divide holds here without a timeout until the unit reports done
                        if (w_is_muldiv && !muldiv_done) state_d = ST_EXECUTE;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready)      state_d = w_is_load ? ST_WRITEBACK : ST_FETCH;
                else if (w_timeout) state_d = ST_FAULT;
                else                wait_d  = w_wait_inc;
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FAULT;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end
        instret_d = instret_q;
        if (state_d == ST_FETCH &&
            (state_q == ST_EXECUTE || state_q == ST_MEM || state_q == ST_WRITEBACK)) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
        fault_d = fault_q | (state_d == ST_FAULT);
    end

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    // Datapath controls from state and decode; everything is held low during reset
    always_comb begin
        w_alu_op             = ALU_OP_ADD;
        pc_write_enable      = 1'b0;
        pc_old_write_enable  = 1'b0;
        inst_write_enable    = 1'b0;
        data_write_enable    = 1'b0;
        regfile_write_enable = 1'b0;
        mem_addr_select      = 1'b0;
        mem_read_enable      = 1'b0;
        mem_write_enable     = 1'b0;
        alu_operand_a_select = OPA_RS1;
        alu_operand_b_select = OPB_RS2;
        reg_writeback_select = WB_ALUOUT;
        next_pc_select       = NPC_ALU;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read_enable      = 1'b1;
                    alu_operand_a_select = OPA_PC;
                    alu_operand_b_select = OPB_FOUR;
                    if (mem_ready) begin
                        inst_write_enable   = 1'b1;
                        pc_old_write_enable = 1'b1;
                        pc_write_enable     = 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_operand_a_select = OPA_PC_OLD;
                    alu_operand_b_select = OPB_IMM;
                end
                ST_EXECUTE: begin
                    case (inst_opcode)
                        OPC_OP: w_alu_op = ALU_OP_OP;
                        OPC_OP_IMM: begin
                            w_alu_op             = ALU_OP_OPIMM;
                            alu_operand_b_select = OPB_IMM;
                        end
                        OPC_LOAD, OPC_STORE: alu_operand_b_select = OPB_IMM;
                        OPC_BRANCH: begin
                            w_alu_op        = ALU_OP_BRANCH;
                            pc_write_enable = w_taken;
                            next_pc_select  = NPC_ALUOUT;
                        end
                        OPC_JAL: begin
                            pc_write_enable      = 1'b1;
                            next_pc_select       = NPC_ALUOUT;
                            regfile_write_enable = 1'b1;
                            reg_writeback_select = WB_PC;
                        end
                        OPC_JALR: begin
                            alu_operand_b_select = OPB_IMM;
                            pc_write_enable      = 1'b1;
                            regfile_write_enable = 1'b1;
                            reg_writeback_select = WB_PC;
                        end
                        OPC_LUI, OPC_AUIPC: begin
                            alu_operand_a_select = OPA_PC_OLD;
                            alu_operand_b_select = OPB_IMM;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_addr_select = 1'b1;
                    if (w_is_load) begin
                        mem_read_enable   = 1'b1;
                        data_write_enable = mem_ready;
                    end else if (w_is_store) begin
                        mem_write_enable  = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    regfile_write_enable = 1'b1;
                    if (w_is_load)     reg_writeback_select = WB_MDR;
                    else if (w_is_lui) reg_writeback_select = WB_IMM;
                end
                default: ;
            endcase
        end
    end

    alu_control u_alu_control (
        .alu_op_type_i  (w_alu_op),
        .inst_funct3_i  (inst_funct3),
        .inst_funct7_i  (inst_funct7),
        .alu_function_o (w_alu_fn)
    );

    assign alu_function = reset ? ALU_ADD : w_alu_fn;
    assign fault        = fault_q;
    assign instret      = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctlpath.sv
// ============================================================================
//  Module      : tb_multicycle_ctlpath
//  Description : Directed, scoreboard-driven bench for multicycle_ctlpath
//                (CNT_WIDTH=4, MAX_WAIT=15, M-extension not built in).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctlpath;
    import multicycle_ctlpath_pkg::*;

    logic       clock;
    logic       reset;
    logic [6:0] inst_opcode;
    logic [2:0] inst_funct3;
    logic [6:0] inst_funct7;
    logic       alu_result_equal_zero;
    logic       mem_ready;
    logic [4:0] alu_function;
    logic       pc_write_enable, pc_old_write_enable, inst_write_enable;
    logic       data_write_enable, regfile_write_enable, mem_addr_select;
    logic       mem_read_enable, mem_write_enable;
    logic [1:0] alu_operand_a_select, alu_operand_b_select, next_pc_select;
    logic [2:0] reg_writeback_select;
    logic       fault;
    logic [3:0] instret;

    multicycle_ctlpath #(.CNT_WIDTH(4), .MAX_WAIT(15)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .inst_opcode           (inst_opcode),
        .inst_funct3           (inst_funct3),
        .inst_funct7           (inst_funct7),
        .alu_result_equal_zero (alu_result_equal_zero),
        .mem_ready             (mem_ready),
        .alu_function          (alu_function),
        .pc_write_enable       (pc_write_enable),
        .pc_old_write_enable   (pc_old_write_enable),
        .inst_write_enable     (inst_write_enable),
        .data_write_enable     (data_write_enable),
        .regfile_write_enable  (regfile_write_enable),
        .mem_addr_select       (mem_addr_select),
        .mem_read_enable       (mem_read_enable),
        .mem_write_enable      (mem_write_enable),
        .alu_operand_a_select  (alu_operand_a_select),
        .alu_operand_b_select  (alu_operand_b_select),
        .reg_writeback_select  (reg_writeback_select),
        .next_pc_select        (next_pc_select),
        .fault                 (fault),
        .instret               (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] alu;
        logic       pcw, pcow, iw, dw, rfw, mas, mre, mwe;
        logic [1:0] asel, bsel;
        logic [2:0] wb;
        logic [1:0] npc;
        logic       flt;
        logic [3:0] ret;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        logic zf;
        ctl_t exp;
        ctl_t msk;
    } step_t;

    ctl_t obs;
    assign obs = {alu_function, pc_write_enable, pc_old_write_enable, inst_write_enable,
                  data_write_enable, regfile_write_enable, mem_addr_select, mem_read_enable,
                  mem_write_enable, alu_operand_a_select, alu_operand_b_select,
                  reg_writeback_select, next_pc_select, fault, instret};

    step_t      sb[$];
    string      tags[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] ret_m  = 4'd0;
    string      cur    = "";

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    function automatic ctl_t base();
        ctl_t c;
        c     = '0;
        c.ret = ret_m;
        return c;
    endfunction

    // Queue one cycle: stimulus (ready, zero flag) plus expected outputs.
    // Writeback source and next-PC select only matter when their enable is set.
    task automatic push(input logic rdy, input logic zf, input ctl_t e,
                        input logic alu_dc, input string phase);
        step_t s;
        ctl_t  m;
        m = '1;
        if (alu_dc) begin
            m.alu  = '0;
            m.asel = '0;
            m.bsel = '0;
        end
        if (!e.rfw) m.wb  = '0;
        if (!e.pcw) m.npc = '0;
        s.rdy = rdy;
        s.zf  = zf;
        s.exp = e;
        s.msk = m;
        sb.push_back(s);
        tags.push_back({cur, ":", phase});
    endtask

    task automatic p_fetch(input logic rdy);
        ctl_t c;
        c = base(); c.mre = 1'b1; c.asel = OPA_PC; c.bsel = OPB_FOUR; c.alu = ALU_ADD;
        if (rdy) begin
            c.pcw = 1'b1; c.pcow = 1'b1; c.iw = 1'b1; c.npc = NPC_ALU;
        end
        push(rdy, 1'b0, c, 1'b0, "fetch");
    endtask

    task automatic p_decode();
        ctl_t c;
        c = base(); c.asel = OPA_PC_OLD; c.bsel = OPB_IMM; c.alu = ALU_ADD;
        push(1'b1, 1'b0, c, 1'b0, "decode");
    endtask

    task automatic p_exec_imm();
        ctl_t c;
        c = base(); c.asel = OPA_RS1; c.bsel = OPB_IMM; c.alu = ALU_ADD;
        push(1'b1, 1'b0, c, 1'b0, "exec");
    endtask

    task automatic p_mem(input logic rdy, input logic load);
        ctl_t c;
        c = base(); c.mas = 1'b1;
        if (load) begin c.mre = 1'b1; c.dw = rdy; end
        else      c.mwe = 1'b1;
        push(rdy, 1'b0, c, 1'b1, "mem");
    endtask

    task automatic p_wb(input logic [2:0] sel);
        ctl_t c;
        c = base(); c.rfw = 1'b1; c.wb = sel;
        push(1'b1, 1'b0, c, 1'b1, "wb");
    endtask

    task automatic p_fault();
        ctl_t c;
        c = base(); c.flt = 1'b1;
        push(1'b0, 1'b0, c, 1'b1, "fault");
    endtask

    task automatic set_inst(input string name, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7);
        cur         = name;
        inst_opcode = op;
        inst_funct3 = f3;
        inst_funct7 = f7;
    endtask

    // Drain the scoreboard: apply each step, compare away from the edge, advance one clock
    task automatic run();
        step_t s;
        string t;
        while (sb.size() != 0) begin
            s = sb.pop_front();
            t = tags.pop_front();
            mem_ready             = s.rdy;
            alu_result_equal_zero = s.zf;
            #1;
            chk(t, 32'(obs & s.msk), 32'(s.exp & s.msk));
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk({tag, ":outputs_in_reset"}, 32'(obs), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ret_m = 4'd0;
    endtask

    initial begin
        ctl_t c;
        reset = 1'b1; mem_ready = 1'b0; alu_result_equal_zero = 1'b0;
        inst_opcode = 7'd0; inst_funct3 = 3'd0; inst_funct7 = 7'd0;
        #1;
        chk("reset:outputs", 32'(obs), 32'd0);
        @(negedge clock);
        chk("reset:held", 32'(obs), 32'd0);
        reset = 1'b0;

        // ADDI x1,x0,5
        set_inst("addi", OPC_OP_IMM, 3'b000, 7'd0);
        p_fetch(1'b1); p_decode(); p_exec_imm(); p_wb(WB_ALUOUT);
        ret_m = ret_m + 4'd1;
        run();

        // BEQ, zero flag set: taken
        set_inst("beq", OPC_BRANCH, 3'b000, 7'd0);
        p_fetch(1'b1); p_decode();
        c = base(); c.alu = ALU_SUB; c.pcw = 1'b1; c.npc = NPC_ALUOUT;
        push(1'b1, 1'b1, c, 1'b0, "exec");
        ret_m = ret_m + 4'd1;
        run();

        // BNE, zero flag set: not taken
        set_inst("bne", OPC_BRANCH, 3'b001, 7'd0);
        p_fetch(1'b1); p_decode();
        c = base(); c.alu = ALU_SUB;
        push(1'b1, 1'b1, c, 1'b0, "exec");
        ret_m = ret_m + 4'd1;
        run();

        // LW with three wait cycles in MEM: 8 cycles total
        set_inst("lw", OPC_LOAD, 3'b010, 7'd0);
        p_fetch(1'b1); p_decode(); p_exec_imm();
        p_mem(1'b0, 1'b1); p_mem(1'b0, 1'b1); p_mem(1'b0, 1'b1); p_mem(1'b1, 1'b1);
        p_wb(WB_MDR);
        ret_m = ret_m + 4'd1;
        run();

        // SW: 4 cycles
        set_inst("sw", OPC_STORE, 3'b010, 7'd0);
        p_fetch(1'b1); p_decode(); p_exec_imm(); p_mem(1'b1, 1'b0);
        ret_m = ret_m + 4'd1;
        run();

        // JAL: 3 cycles, link register written with PC
        set_inst("jal", OPC_JAL, 3'b000, 7'd0);
        p_fetch(1'b1); p_decode();
        c = base(); c.pcw = 1'b1; c.npc = NPC_ALUOUT; c.rfw = 1'b1; c.wb = WB_PC;
        push(1'b1, 1'b0, c, 1'b1, "exec");
        ret_m = ret_m + 4'd1;
        run();

        // Ready arrives on the last allowed wait cycle: the fetch completes normally
        set_inst("nop_late_ready", OPC_OP_IMM, 3'b000, 7'd0);
        for (int i = 0; i < 14; i++) p_fetch(1'b0);
        p_fetch(1'b1); p_decode(); p_exec_imm(); p_wb(WB_ALUOUT);
        ret_m = ret_m + 4'd1;
        run();

        // All-zero opcode is illegal: DECODE -> FAULT, nothing retires
        set_inst("illegal_op", 7'b0000000, 3'b000, 7'd0);
        p_fetch(1'b1); p_decode(); p_fault(); p_fault();
        run();
        do_reset("illegal_op");

        // MUL without the M-extension is illegal
        set_inst("mul_disabled", OPC_OP, 3'b000, FUNCT7_MULDIV);
        p_fetch(1'b1); p_decode(); p_fault();
        run();
        do_reset("mul_disabled");

        // Sixteen NOPs wrap the 4-bit retired counter back to 0
        set_inst("nop16", OPC_OP_IMM, 3'b000, 7'd0);
        for (int i = 0; i < 16; i++) begin
            p_fetch(1'b1); p_decode(); p_exec_imm(); p_wb(WB_ALUOUT);
            ret_m = ret_m + 4'd1;
        end
        run();

        // Fetch never acknowledged: FAULT after 15 wait cycles, then reset clears it
        set_inst("timeout", OPC_OP_IMM, 3'b000, 7'd0);
        for (int i = 0; i < 15; i++) p_fetch(1'b0);
        p_fault(); p_fault();
        run();
        do_reset("timeout");

        // Reset in the middle of a load: no register write, restart in FETCH
        set_inst("lw_abort", OPC_LOAD, 3'b010, 7'd0);
        p_fetch(1'b1); p_decode(); p_exec_imm(); p_mem(1'b0, 1'b1); p_mem(1'b0, 1'b1);
        run();
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("lw_abort:outputs_in_reset", 32'(obs), 32'd0);
        @(posedge clock);
        #1;
        chk("lw_abort:regfile_we", 32'(regfile_write_enable), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ret_m = 4'd0;
        cur   = "after_abort";
        p_fetch(1'b0);
        run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
